// File: rtl/branch_predict_pkg.sv
// Shared types and defaults for the gshare direction predictor.
// Holds counter encodings, table sizing and the stage metadata bundle.
package branch_predict_pkg;

  localparam int PHT_BITS_DEF = 6;
  localparam int GHR_BITS_DEF = 6;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Per-stage prediction bundle carried D -> E -> M.
  typedef struct packed {
    logic                    valid;
    logic                    pred;
    logic [PHT_BITS_DEF-1:0] idx;
  } meta_t;

endpackage

// File: rtl/branch_predict_sat.sv
// sat_counter2: 2-bit saturating counter next-state function.
// Ports: cnt_i current count, take_i direction, cnt_o next count.
module sat_counter2
  import branch_predict_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       take_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (take_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict.sv
// Gshare predictor: predicts in D, resolves and trains in M.
// Ports: clk/rst, pcD/branchD in, flushE/flushM from hazard unit,
// actual_takeM outcome; pred_takeD, pred_resM, branchM out.
// The metadata idx width comes from the package default PHT_BITS.
module branch_predict
  import branch_predict_pkg::*;
#(
  parameter int PHT_BITS = PHT_BITS_DEF,
  parameter int GHR_BITS = GHR_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        flushE,
  input  logic        flushM,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        pred_resM,
  output logic        branchM
);

  localparam int ENTRIES = 1 << PHT_BITS;

  logic [1:0]          pht_q [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  meta_t               metaE_q, metaE_d;
  meta_t               metaM_q, metaM_d;
  meta_t               metaD;
  logic [PHT_BITS-1:0] idxD;
  logic [1:0]          cnt_d;
  logic                unused_pc;

  assign unused_pc = ^{pcD[31:PHT_BITS+2], pcD[1:0]};

  assign idxD       = pcD[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q);
  assign pred_takeD = branchD & pht_q[idxD][1];

  assign branchM   = metaM_q.valid;
  assign pred_resM = metaM_q.valid & (metaM_q.pred != actual_takeM);

  // Flush wins over the incoming bundle: a flushed slot is a bubble.
  always_comb begin
    metaD.valid = branchD;
    metaD.pred  = pred_takeD;
    metaD.idx   = idxD;
    metaE_d     = flushE ? '0 : metaD;
    metaM_d     = flushM ? '0 : metaE_q;
    ghr_d       = {ghr_q[GHR_BITS-2:0], actual_takeM};
  end

  // Train with the index captured at predict time, not a fresh one.
  sat_counter2 u_sat (
    .cnt_i  (pht_q[metaM_q.idx]),
    .take_i (actual_takeM),
    .cnt_o  (cnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WNT;
      ghr_q   <= '0;
      metaE_q <= '0;
      metaM_q <= '0;
    end else begin
      metaE_q <= metaE_d;
      metaM_q <= metaM_d;
      if (metaM_q.valid) begin
        pht_q[metaM_q.idx] <= cnt_d;
        ghr_q              <= ghr_d;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict.sv
// Directed self-checking bench for branch_predict.
// One task per scenario, inline comparisons, one summary line.
module tb_branch_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD;
  logic        flushE;
  logic        flushM;
  logic        actual_takeM;
  logic        pred_takeD;
  logic        pred_resM;
  logic        branchM;

  int checks = 0;
  int errors = 0;

  branch_predict dut (
    .clk          (clk),
    .rst          (rst),
    .pcD          (pcD),
    .branchD      (branchD),
    .flushE       (flushE),
    .flushM       (flushM),
    .actual_takeM (actual_takeM),
    .pred_takeD   (pred_takeD),
    .pred_resM    (pred_resM),
    .branchM      (branchM)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branchD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    actual_takeM = 1'b0;
    pcD = 32'h0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    branchD = 1'b1;
    pcD = 32'h40;
    #1;
    checks++;
    if (pred_takeD !== 1'b0) begin
      errors++;
      $display("FAIL rst_pred: got %0b expected 0", pred_takeD);
    end
    checks++;
    if (branchM !== 1'b0) begin
      errors++;
      $display("FAIL rst_branchM: got %0b expected 0", branchM);
    end
    checks++;
    if (pred_resM !== 1'b0) begin
      errors++;
      $display("FAIL rst_resM: got %0b expected 0", pred_resM);
    end
    checks++;
    if (dut.ghr_q !== 6'h0) begin
      errors++;
      $display("FAIL rst_ghr: got %0h expected 0", dut.ghr_q);
    end
    checks++;
    if (dut.pht_q[16] !== 2'b01) begin
      errors++;
      $display("FAIL rst_pht: got %0b expected 01", dut.pht_q[16]);
    end
  endtask

  task automatic test_single_branch();
    // branch at 0x40 sits in D from test_reset
    step();
    branchD = 1'b0;
    step();
    actual_takeM = 1'b1;
    #1;
    checks++;
    if (pred_resM !== 1'b1) begin
      errors++;
      $display("FAIL single_resM: got %0b expected 1", pred_resM);
    end
    checks++;
    if (branchM !== 1'b1) begin
      errors++;
      $display("FAIL single_branchM: got %0b expected 1", branchM);
    end
    step();
    actual_takeM = 1'b0;
    checks++;
    if (dut.pht_q[16] !== 2'b10) begin
      errors++;
      $display("FAIL single_pht: got %0b expected 10", dut.pht_q[16]);
    end
    checks++;
    if (dut.ghr_q !== 6'b000001) begin
      errors++;
      $display("FAIL single_ghr: got %0h expected 01", dut.ghr_q);
    end
  endtask

  task automatic test_train();
    logic [1:0] exp_ctr  [4];
    logic       exp_pred [4];
    logic [5:0] g;
    exp_ctr  = '{2'b10, 2'b11, 2'b11, 2'b11};
    exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    g = 6'h00;
    for (int k = 0; k < 4; k++) begin
      // keep idx at 0x10 as the history shifts in ones
      pcD = {24'h0, 6'h10 ^ g, 2'b00};
      branchD = 1'b1;
      #1;
      checks++;
      if (pred_takeD !== exp_pred[k]) begin
        errors++;
        $display("FAIL train_pred%0d: got %0b expected %0b",
                 k, pred_takeD, exp_pred[k]);
      end
      step();
      branchD = 1'b0;
      step();
      actual_takeM = 1'b1;
      #1;
      checks++;
      if (pred_resM !== !exp_pred[k]) begin
        errors++;
        $display("FAIL train_resM%0d: got %0b expected %0b",
                 k, pred_resM, !exp_pred[k]);
      end
      step();
      actual_takeM = 1'b0;
      g = {g[4:0], 1'b1};
      checks++;
      if (dut.pht_q[16] !== exp_ctr[k]) begin
        errors++;
        $display("FAIL train_pht%0d: got %0b expected %0b",
                 k, dut.pht_q[16], exp_ctr[k]);
      end
    end
    pcD = {24'h0, 6'h10 ^ g, 2'b00};
    branchD = 1'b0;
    #1;
    checks++;
    if (pred_takeD !== 1'b0) begin
      errors++;
      $display("FAIL nonbranch_pred: got %0b expected 0", pred_takeD);
    end
    branchD = 1'b1;
    #1;
    checks++;
    if (pred_takeD !== 1'b1) begin
      errors++;
      $display("FAIL trained_pred: got %0b expected 1", pred_takeD);
    end
    branchD = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    branchD = 1'b1;
    pcD = 32'h40;
    flushE = 1'b1;
    #1;
    step();
    flushE = 1'b0;
    branchD = 1'b0;
    step();
    actual_takeM = 1'b1;
    #1;
    checks++;
    if (branchM !== 1'b0) begin
      errors++;
      $display("FAIL flushE_branchM: got %0b expected 0", branchM);
    end
    checks++;
    if (pred_resM !== 1'b0) begin
      errors++;
      $display("FAIL flushE_resM: got %0b expected 0", pred_resM);
    end
    step();
    actual_takeM = 1'b0;
    checks++;
    if (dut.ghr_q !== 6'h0 || dut.pht_q[16] !== 2'b01) begin
      errors++;
      $display("FAIL flushE_state: got ghr %0h pht %0b expected 0/01",
               dut.ghr_q, dut.pht_q[16]);
    end
    branchD = 1'b1;
    step();
    branchD = 1'b0;
    flushM = 1'b1;
    step();
    flushM = 1'b0;
    actual_takeM = 1'b1;
    #1;
    checks++;
    if (branchM !== 1'b0 || pred_resM !== 1'b0) begin
      errors++;
      $display("FAIL flushM_kill: got branchM %0b resM %0b expected 0/0",
               branchM, pred_resM);
    end
    step();
    actual_takeM = 1'b0;
    checks++;
    if (dut.ghr_q !== 6'h0) begin
      errors++;
      $display("FAIL flushM_ghr: got %0h expected 0", dut.ghr_q);
    end
  endtask

  task automatic test_same_index();
    do_reset();
    branchD = 1'b1;
    pcD = 32'h14;
    step();
    branchD = 1'b0;
    step();
    actual_takeM = 1'b1;
    branchD = 1'b1;
    pcD = 32'h14;
    #1;
    checks++;
    if (pred_takeD !== 1'b0) begin
      errors++;
      $display("FAIL rw_old_pred: got %0b expected 0", pred_takeD);
    end
    checks++;
    if (pred_resM !== 1'b1) begin
      errors++;
      $display("FAIL rw_resM: got %0b expected 1", pred_resM);
    end
    step();
    actual_takeM = 1'b0;
    // ghr is now 1, so pc 0x10 maps back onto idx 5
    pcD = 32'h10;
    #1;
    checks++;
    if (pred_takeD !== 1'b1) begin
      errors++;
      $display("FAIL rw_new_pred: got %0b expected 1", pred_takeD);
    end
    checks++;
    if (dut.pht_q[5] !== 2'b10) begin
      errors++;
      $display("FAIL rw_pht: got %0b expected 10", dut.pht_q[5]);
    end
    branchD = 1'b0;
  endtask

  task automatic test_nt_sat();
    do_reset();
    pcD = 32'h20;
    for (int k = 0; k < 4; k++) begin
      branchD = 1'b1;
      #1;
      checks++;
      if (pred_takeD !== 1'b0) begin
        errors++;
        $display("FAIL nt_pred%0d: got %0b expected 0", k, pred_takeD);
      end
      step();
      branchD = 1'b0;
      step();
      actual_takeM = 1'b0;
      #1;
      checks++;
      if (branchM !== 1'b1 || pred_resM !== 1'b0) begin
        errors++;
        $display("FAIL nt_res%0d: got branchM %0b resM %0b expected 1/0",
                 k, branchM, pred_resM);
      end
      step();
      checks++;
      if (dut.pht_q[8] !== 2'b00) begin
        errors++;
        $display("FAIL nt_pht%0d: got %0b expected 00", k, dut.pht_q[8]);
      end
    end
    checks++;
    if (dut.ghr_q !== 6'h0) begin
      errors++;
      $display("FAIL nt_ghr: got %0h expected 0", dut.ghr_q);
    end
  endtask

  task automatic test_reset_midflight();
    int bad;
    do_reset();
    branchD = 1'b1;
    pcD = 32'h40;
    step();
    branchD = 1'b0;
    step();
    actual_takeM = 1'b1;
    step();
    actual_takeM = 1'b0;
    // pht[0x10] = 10, ghr = 1; now put A in M and B in E
    branchD = 1'b1;
    pcD = 32'h40;
    step();
    pcD = 32'h44;
    step();
    branchD = 1'b0;
    #1;
    checks++;
    if (branchM !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got branchM %0b expected 1", branchM);
    end
    rst = 1'b1;
    actual_takeM = 1'b1;
    step();
    rst = 1'b0;
    actual_takeM = 1'b0;
    #1;
    checks++;
    if (branchM !== 1'b0 || pred_resM !== 1'b0) begin
      errors++;
      $display("FAIL mid_outs: got branchM %0b resM %0b expected 0/0",
               branchM, pred_resM);
    end
    checks++;
    if (dut.ghr_q !== 6'h0) begin
      errors++;
      $display("FAIL mid_ghr: got %0h expected 0", dut.ghr_q);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.pht_q[i] !== 2'b01) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_pht: got %0d entries not 01 expected 0", bad);
    end
    step();
    checks++;
    if (branchM !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain: got branchM %0b expected 0", branchM);
    end
  endtask

  initial begin
    test_reset();
    test_single_branch();
    test_train();
    test_flush();
    test_same_index();
    test_nt_sat();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
